// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu. A request is taken when start is high in IDLE;
// res/flag_next are valid in the one cycle done is high and held until the next accepted start.
interface seq_alu_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [4:0]       opsel;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             Cflag;
  logic             Oflag;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [3:0]       flag_next;
  logic [1:0]       state_dbg;

  modport master (
    output start, opsel, srcA, srcB, Cflag, Oflag,
    input  busy, done, res, flag_next, state_dbg
  );
  modport slave (
    input  start, opsel, srcA, srcB, Cflag, Oflag,
    output busy, done, res, flag_next, state_dbg
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic, iterative MUL/DIV/MOD (one bit per cycle)
// and bit-serial shifts/rotates. Result and {ZF,NF,CF,OF} are registered on entry to DONE.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave alu
);
  localparam int CW = SHW + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [4:0] OP_PASS = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_INC = 5'd3;
  localparam logic [4:0] OP_DEC  = 5'd4,  OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_XOR = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8,  OP_NEG = 5'd9,  OP_MUL = 5'd10, OP_DIV = 5'd11;
  localparam logic [4:0] OP_MOD  = 5'd12, OP_RSL = 5'd16, OP_LSL = 5'd17, OP_RSA = 5'd18;
  localparam logic [4:0] OP_LSA  = 5'd19, OP_ROR = 5'd20, OP_ROL = 5'd21, OP_RCR = 5'd22;
  localparam logic [4:0] OP_RCL  = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             c_q, of_q, chg_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flag_q;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic cf,
                                            input logic ovf);
    return {(r == '0), r[WIDTH-1], cf, ovf};
  endfunction

  // Operations that finish on the accepting edge, straight from the request inputs.
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_w, sub_w;
  logic             is_multi;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cf, sc_of;

  always_comb begin
    k        = alu.srcB[SHW-1:0];
    addend   = (alu.opsel == OP_INC || alu.opsel == OP_DEC) ? ONE : alu.srcB;
    add_w    = {1'b0, alu.srcA} + {1'b0, addend};
    sub_w    = {1'b0, alu.srcA} - {1'b0, addend};
    is_multi = 1'b0;
    sc_res   = '0;
    sc_cf    = alu.Cflag;
    sc_of    = alu.Oflag;
    case (alu.opsel)
      OP_PASS: sc_res = alu.srcB;
      OP_ADD, OP_INC: begin
        sc_res = add_w[WIDTH-1:0];
        sc_cf  = add_w[WIDTH];
        sc_of  = (alu.srcA[WIDTH-1] == addend[WIDTH-1]) &&
                 (add_w[WIDTH-1] != alu.srcA[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_cf  = sub_w[WIDTH];
        sc_of  = (alu.srcA[WIDTH-1] != addend[WIDTH-1]) &&
                 (sub_w[WIDTH-1] != alu.srcA[WIDTH-1]);
      end
      OP_AND: sc_res = alu.srcA & alu.srcB;
      OP_OR:  sc_res = alu.srcA | alu.srcB;
      OP_XOR: sc_res = alu.srcA ^ alu.srcB;
      OP_NOT: sc_res = ~alu.srcA;
      OP_NEG: sc_res = '0 - alu.srcA;
      OP_MUL: is_multi = 1'b1;
      OP_DIV, OP_MOD: begin
        if (alu.srcB == '0) begin
          sc_res = (alu.opsel == OP_DIV) ? '1 : alu.srcA;
          sc_cf  = 1'b0;
          sc_of  = 1'b1;
        end else begin
          is_multi = 1'b1;
        end
      end
      OP_RSL, OP_LSL, OP_RSA, OP_LSA, OP_ROR, OP_ROL, OP_RCR, OP_RCL: begin
        if (k == '0) sc_res = alu.srcA;
        else         is_multi = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration step; lo_q is multiplier / dividend-quotient / shift value, hi_q is
  // the product high half or partial remainder, c_q is the carry ring bit.
  logic [WIDTH:0]   mac_w, rem_w, rsub_w;
  logic             q_bit;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             c_d, chg_d;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cf, fin_of;

  always_comb begin
    mac_w  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_w  = {hi_q, lo_q[WIDTH-1]};
    rsub_w = rem_w - {1'b0, b_q};
    q_bit  = (rem_w >= {1'b0, b_q});
    hi_d   = hi_q;
    lo_d   = lo_q;
    c_d    = c_q;
    chg_d  = chg_q;
    case (op_q)
      OP_MUL: begin
        hi_d = mac_w[WIDTH:1];
        lo_d = {mac_w[0], lo_q[WIDTH-1:1]};
      end
      OP_DIV, OP_MOD: begin
        hi_d = q_bit ? rsub_w[WIDTH-1:0] : rem_w[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], q_bit};
      end
      OP_RSL: begin c_d = lo_q[0];       lo_d = {1'b0, lo_q[WIDTH-1:1]}; end
      OP_RSA: begin c_d = lo_q[0];       lo_d = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]}; end
      OP_ROR: begin c_d = lo_q[0];       lo_d = {lo_q[0], lo_q[WIDTH-1:1]}; end
      OP_ROL: begin c_d = lo_q[WIDTH-1]; lo_d = {lo_q[WIDTH-2:0], lo_q[WIDTH-1]}; end
      OP_RCR: begin c_d = lo_q[0];       lo_d = {c_q, lo_q[WIDTH-1:1]}; end
      OP_RCL: begin c_d = lo_q[WIDTH-1]; lo_d = {lo_q[WIDTH-2:0], c_q}; end
      OP_LSL, OP_LSA: begin
        c_d   = lo_q[WIDTH-1];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        chg_d = chg_q | (lo_q[WIDTH-1] ^ lo_q[WIDTH-2]);
      end
      default: ;
    endcase

    fin_res = lo_d;
    fin_cf  = c_d;
    fin_of  = (op_q == OP_LSA) ? chg_d : of_q;
    case (op_q)
      OP_MUL: begin fin_cf = |hi_d; fin_of = |hi_d; end
      OP_DIV: begin fin_cf = 1'b0;  fin_of = 1'b0;  end
      OP_MOD: begin fin_res = hi_d; fin_cf = 1'b0; fin_of = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      of_q    <= 1'b0;
      chg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      flag_q  <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (alu.start) begin
            op_q   <= alu.opsel;
            hi_q   <= '0;
            lo_q   <= alu.srcA;
            b_q    <= alu.srcB;
            c_q    <= alu.Cflag;
            of_q   <= alu.Oflag;
            chg_q  <= 1'b0;
            busy_q <= 1'b1;
            if (is_multi) begin
              state_q <= S_EXEC;
              cnt_q   <= (alu.opsel == OP_MUL || alu.opsel == OP_DIV || alu.opsel == OP_MOD)
                         ? CW'(WIDTH) : {1'b0, k};
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= sc_res;
              flag_q  <= pack_flags(sc_res, sc_cf, sc_of);
            end
          end
        end
        S_EXEC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          c_q   <= c_d;
          chg_q <= chg_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            res_q   <= fin_res;
            flag_q  <= pack_flags(fin_res, fin_cf, fin_of);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu.busy      = busy_q;
  assign alu.done      = done_q;
  assign alu.res       = res_q;
  assign alu.flag_next = flag_q;
  assign alu.state_dbg = state_q;
endmodule
